// File: rtl/mem_wb_stage.sv
// Memory-access stage with MEM/WB pipeline register: issues loads/stores on a
// req/ack bus, stalls upstream while an access is outstanding, and times out dead accesses.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned REG_SIZE   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Regfile_weM,
  input  logic                  DataMem_weM,
  input  logic                  memReadM,
  input  logic [REG_SIZE-1:0]   wirteRegAddrM,
  input  logic [WORD_WIDTH-1:0] aluOutM,
  input  logic [WORD_WIDTH-1:0] writeDataM,
  output logic                  stallM,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [WORD_WIDTH-1:0] dmem_addr,
  output logic [WORD_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [WORD_WIDTH-1:0] dmem_rdata,
  output logic                  validW,
  output logic                  Regfile_weW,
  output logic [REG_SIZE-1:0]   wirteRegAddrW,
  output logic [WORD_WIDTH-1:0] resultW,
  output logic                  bus_err
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] count;
  logic       memop;
  logic       timeout_hit;

  assign memop       = DataMem_weM | memReadM;
  assign timeout_hit = (state_q == S_WAIT) && (count == TO_LAST);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    stallM  = 1'b0;
    case (state_q)
      S_IDLE: begin
        stallM = memop;
        if (memop) state_d = S_WAIT;
      end
      S_WAIT: begin
        stallM = ~dmem_ack & ~timeout_hit;
        if (dmem_ack || timeout_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!rst) stallM = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      count         <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      validW        <= 1'b0;
      Regfile_weW   <= 1'b0;
      wirteRegAddrW <= '0;
      resultW       <= '0;
      bus_err       <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (memop) begin
            dmem_req    <= 1'b1;
            dmem_we     <= DataMem_weM;
            dmem_addr   <= aluOutM;
            dmem_wdata  <= writeDataM;
            count       <= '0;
            validW      <= 1'b0;
            Regfile_weW <= 1'b0;
          end else begin
            validW        <= 1'b1;
            Regfile_weW   <= Regfile_weM;
            wirteRegAddrW <= wirteRegAddrM;
            resultW       <= aluOutM;
          end
        end
        S_WAIT: begin
          // An ack in the timeout cycle still completes the access normally.
          if (dmem_ack) begin
            dmem_req      <= 1'b0;
            validW        <= 1'b1;
            Regfile_weW   <= Regfile_weM;
            wirteRegAddrW <= wirteRegAddrM;
            resultW       <= dmem_we ? aluOutM : dmem_rdata;
          end else if (timeout_hit) begin
            dmem_req    <= 1'b0;
            validW      <= 1'b1;
            Regfile_weW <= 1'b0;
            resultW     <= '0;
            bus_err     <= 1'b1;
          end else if (count != 8'hFF) begin
            count <= count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: the driver queues expected W bundles,
// an independent monitor pops and compares them whenever validW is seen.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        Regfile_weM, DataMem_weM, memReadM;
  logic [4:0]  wirteRegAddrM;
  logic [31:0] aluOutM, writeDataM;
  logic        stallM, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        validW, Regfile_weW, bus_err;
  logic [4:0]  wirteRegAddrW;
  logic [31:0] resultW;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] res;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b1;
  int   ack_at = -1;
  int   req_cycles = 0;
  logic stray_ack = 1'b0;

  always #5 clk = ~clk;

  // Memory model: ack arrives ack_at cycles after the request first appears.
  assign dmem_ack = (dmem_req && (req_cycles == ack_at)) || stray_ack;
  always @(posedge clk) req_cycles <= dmem_req ? req_cycles + 1 : 0;

  mem_wb_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .Regfile_weM(Regfile_weM), .DataMem_weM(DataMem_weM), .memReadM(memReadM),
    .wirteRegAddrM(wirteRegAddrM), .aluOutM(aluOutM), .writeDataM(writeDataM),
    .stallM(stallM), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .validW(validW), .Regfile_weW(Regfile_weW), .wirteRegAddrW(wirteRegAddrW),
    .resultW(resultW), .bus_err(bus_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst === 1'b1 && validW === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_retire", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("w_we", {31'd0, Regfile_weW}, {31'd0, e.we});
        check("w_result", resultW, e.res);
        if (e.we) check("w_addr", {27'd0, wirteRegAddrW}, {27'd0, e.rd});
      end
    end
  end

  // Drives one M-stage instruction, queues its expected W bundle and waits
  // for the edge at which it retires; stall and request lengths are checked.
  task automatic issue(input string name, input logic rf_we, input logic dm_we, input logic mem_rd,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wdata,
                       input int ack_delay, input logic exp_we, input logic [31:0] exp_res,
                       input int exp_stall);
    int  stalls = 0;
    int  reqs = 0;
    bit  retired = 1'b0;
    Regfile_weM = rf_we; DataMem_weM = dm_we; memReadM = mem_rd;
    wirteRegAddrM = rd; aluOutM = alu; writeDataM = wdata;
    ack_at = ack_delay;
    q.push_back('{we: exp_we, rd: rd, res: exp_res});
    for (int i = 0; i < 64 && !retired; i++) begin
      @(negedge clk);
      if (dmem_req) begin
        reqs++;
        check({name, "_addr"}, dmem_addr, alu);
        check({name, "_we"}, {31'd0, dmem_we}, {31'd0, dm_we});
        if (dm_we) check({name, "_wdata"}, dmem_wdata, wdata);
      end
      if (stallM) stalls++;
      else retired = 1'b1;
    end
    if (!retired) check({name, "_retire_bound"}, 32'd0, 32'd1);
    check({name, "_stall_cycles"}, stalls, exp_stall);
    check({name, "_req_cycles"}, reqs, (dm_we | mem_rd) ? exp_stall : 0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0;
    Regfile_weM = 0; DataMem_weM = 0; memReadM = 0;
    wirteRegAddrM = '0; aluOutM = '0; writeDataM = '0; dmem_rdata = '0;
    #1;
    check("rst_validW", {31'd0, validW}, 32'd0);
    check("rst_resultW", resultW, 32'd0);
    check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;

    issue("alu0", 1, 0, 0, 5'd5, 32'h0000_1234, 0, -1, 1, 32'h0000_1234, 0);
    issue("alu1", 1, 0, 0, 5'd6, 32'h1111_0000, 0, -1, 1, 32'h1111_0000, 0);
    issue("alu2", 0, 0, 0, 5'd7, 32'h2222_2222, 0, -1, 0, 32'h2222_2222, 0);
    issue("alu3", 1, 0, 0, 5'd31, 32'hFFFF_FFFF, 0, -1, 1, 32'hFFFF_FFFF, 0);

    dmem_rdata = 32'hDEAD_BEEF;
    issue("load0", 1, 0, 1, 5'd3, 32'h0000_0040, 0, 0, 1, 32'hDEAD_BEEF, 1);
    issue("store3", 0, 1, 0, 5'd0, 32'h0000_0080, 32'hA5A5_A5A5, 2, 0, 32'h0000_0080, 3);
    issue("rdwr", 1, 1, 1, 5'd9, 32'h0000_00C0, 32'h0BAD_F00D, 0, 1, 32'h0000_00C0, 1);

    dmem_rdata = 32'h1357_9BDF;
    issue("ack_at_to", 1, 0, 1, 5'd12, 32'h0000_0100, 0, 3, 1, 32'h1357_9BDF, 4);
    check("no_err_after_late_ack", {31'd0, bus_err}, 32'd0);

    issue("timeout", 1, 0, 1, 5'd13, 32'h0000_0200, 0, -1, 0, 32'h0, 4);
    check("bus_err_set", {31'd0, bus_err}, 32'd1);
    stray_ack = 1'b1;
    issue("alu_stray_ack", 1, 0, 0, 5'd14, 32'h0000_5555, 0, -1, 1, 32'h0000_5555, 0);
    stray_ack = 1'b0;
    issue("alu_sticky", 1, 0, 0, 5'd15, 32'h0000_6666, 0, -1, 1, 32'h0000_6666, 0);
    check("bus_err_sticky", {31'd0, bus_err}, 32'd1);

    // Reset in the second WAIT cycle of a load: nothing retires.
    Regfile_weM = 1; memReadM = 1; wirteRegAddrM = 5'd7; aluOutM = 32'h0000_0300;
    ack_at = -1;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("mid_rst_stallM", {31'd0, stallM}, 32'd0);
    check("mid_rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("mid_rst_dmem_addr", dmem_addr, 32'd0);
    check("mid_rst_validW", {31'd0, validW}, 32'd0);
    check("mid_rst_weW", {31'd0, Regfile_weW}, 32'd0);
    check("mid_rst_addrW", {27'd0, wirteRegAddrW}, 32'd0);
    check("mid_rst_resultW", resultW, 32'd0);
    check("mid_rst_bus_err", {31'd0, bus_err}, 32'd0);
    Regfile_weM = 0; memReadM = 0;
    @(posedge clk); #2;
    rst = 1'b1;
    issue("alu_after_rst", 1, 0, 0, 5'd21, 32'h0000_ABCD, 0, -1, 1, 32'h0000_ABCD, 0);

    @(negedge clk); #1;
    mon_en = 1'b0;
    check("scoreboard_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register. It consumes the M-stage outputs of the EX/MEM register and performs loads and stores over a req/ack data-memory bus that may take several cycles. It stalls upstream while an access is outstanding and delivers a registered writeback bundle to the W stage. A bounded timeout keeps a dead memory from hanging the pipeline.

## Interface
- `TIMEOUT`, default 16: maximum cycles spent in WAIT before the access is abandoned; legal range 2..255.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `Regfile_weM`  in  1: M-stage register-file write enable.
- `DataMem_weM`  in  1: M-stage store.
- `memReadM`  in  1: M-stage load.
- `wirteRegAddrM`  in  `REG_SIZE` (5): destination register.
- `aluOutM`  in  `WORD_WIDTH` (32): ALU result, which is also the memory address.
- `writeDataM`  in  `WORD_WIDTH`: store data.
- `stallM`  out  1: combinational; upstream holds EX/MEM contents while this is 1.
- `dmem_req`  out  1: registered memory request.
- `dmem_we`  out  1: registered; 1 = write.
- `dmem_addr`  out  `WORD_WIDTH`: registered address.
- `dmem_wdata`  out  `WORD_WIDTH`: registered write data.
- `dmem_ack`  in  1: memory completion; may be combinational from `dmem_req`.
- `dmem_rdata`  in  `WORD_WIDTH`: load data, valid when `dmem_ack`=1.
- `validW`  out  1: W bundle holds a retired instruction.
- `Regfile_weW`  out  1: W-stage register write enable.
- `wirteRegAddrW`  out  `REG_SIZE`: W destination.
- `resultW`  out  `WORD_WIDTH`: writeback value.
- `bus_err`  out  1: sticky timeout flag; cleared only by reset.

## Operation
- The M-stage inputs are a memory op when `memop = DataMem_weM | memReadM`.
- If both are 1, the op is treated as a store. `resultW` is then `aluOutM` and no load data is used.
- FSM states: IDLE, WAIT.
- IDLE with no memop:
  - At the next edge, `validW`=1, `Regfile_weW`=`Regfile_weM`, `wirteRegAddrW`=`wirteRegAddrM`, `resultW`=`aluOutM`.
  - `stallM`=0.
- IDLE with memop:
  - `stallM`=1.
  - At the next edge: capture `dmem_addr`=`aluOutM`, `dmem_wdata`=`writeDataM`, `dmem_we`=`DataMem_weM`.
  - Also at that edge: set `dmem_req`=1, clear the timeout counter, go to WAIT, and load a bubble into W (`validW`=0, `Regfile_weW`=0; address and result hold).
- WAIT: `dmem_req` and the `dmem_*` signals are held stable. `stallM = ~dmem_ack & ~timeout_hit`, where `timeout_hit = (count == TIMEOUT-1)`.
- WAIT with `dmem_ack`=1:
  - At the edge: W gets `validW`=1, `Regfile_weW`=`Regfile_weM`, `wirteRegAddrW`=`wirteRegAddrM`.
  - `resultW` = `dmem_rdata` for a load, `aluOutM` for a store.
  - `dmem_req`=0; go to IDLE.
- WAIT with no ack and not `timeout_hit`: count increments and the state stays WAIT; W holds a bubble.
- WAIT with `timeout_hit` and no ack:
  - At the edge: W gets `validW`=1, `Regfile_weW`=0, `resultW`=0.
  - `bus_err` is set to 1, `dmem_req`=0, and the state goes to IDLE.
- `dmem_ack` in the same cycle as `timeout_hit`: the ack wins and completes normally with no error.
- `dmem_ack` seen in IDLE, or in the first cycle of IDLE after a timeout: ignored, no effect.
- The M-stage inputs stay stable while `stallM`=1 (upstream contract). The instruction in M retires at the edge where `stallM`=0.
- The counter is 8 bits wide and saturates; it never wraps within a legal `TIMEOUT`.

## Timing
- Reset (`rst`=0, asynchronous):
  - State goes to IDLE and the counter to 0.
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `validW`, `Regfile_weW`, `wirteRegAddrW`, `resultW` and `bus_err` all go to 0.
  - `stallM` is forced to 0 while `rst`=0.
  - Reset mid-access abandons the request immediately; no W retirement occurs.
- Non-memory op: 1-cycle latency from M to W, no stall, so back-to-back throughput is 1 per cycle.
- Memory op with ack in the first WAIT cycle: 2 cycles occupancy and 1 stall cycle. W updates at the end of the WAIT cycle.
- Memory op with ack N cycles after WAIT entry (N ≥ 1): occupancy 1+N, stall cycles N.
- Timeout: occupancy is 1+`TIMEOUT`. `bus_err` rises at the same edge as the error retirement.
- After reset release, the first edge evaluates IDLE normally.

## Test plan
- Reset then ALU ops: `aluOutM`=0x0000_1234 with `Regfile_weM`=1 and `wirteRegAddrM`=5 -> next edge gives `validW`=1, `resultW`=0x1234, `wirteRegAddrW`=5. Then 3 ops back-to-back retire on 3 consecutive edges with `stallM` never asserted.
- Load with zero-wait memory: `memReadM`=1, `aluOutM`=0x40, ack combinational with `dmem_rdata`=0xDEAD_BEEF -> `stallM` high for 1 cycle, `dmem_addr`=0x40, `dmem_we`=0. Then `resultW`=0xDEADBEEF, `validW`=1 two edges after presentation, with a bubble in between.
- Store with ack after 3 WAIT cycles: `DataMem_weM`=1, `writeDataM`=0xA5A5_A5A5, `aluOutM`=0x80 -> `dmem_we`=1 and `dmem_wdata`=0xA5A5A5A5 held for 3 cycles. `stallM` is high for 3 cycles, then `resultW`=0x80, `Regfile_weW`=0.
- Timeout with `TIMEOUT`=4 and ack never asserted -> `dmem_req` high for exactly 4 cycles. Then `validW`=1, `Regfile_weW`=0, `resultW`=0, `bus_err`=1 sticky through subsequent ALU ops; a late ack is ignored.
- Ack coincident with `timeout_hit` -> normal completion with load data and `bus_err` remaining 0.
- Assert `rst`=0 in the second WAIT cycle of a load -> all outputs are 0 immediately and `stallM`=0. After release, the next ALU op retires in 1 cycle.
